tipi_link_seq: RTL and testbench
================================

Name: tipi_link_seq

Overview:
- Hardware sequencer for the TIPI serial register link, replacing host bit-banging of r_clk/r_le/r_rt/r_cd.
- A local requester issues single-byte transactions:
  - read of a TI-originated register (TD or TC), or
  - write of an RPi-originated register (RD or RC).
- The block generates the select, shift-clock and latch waveforms, then shifts 8 bits MSB first.
- It sits between the link master logic and the link pins of the TIPI CPLD register fabric.

Parameters:
HALF, 2, clk cycles per r_clk half-period and per setup/latch phase; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
req  input  1  start transaction; sampled only in IDLE
req_rt  input  1  1 = read TI register (TD/TC), 0 = write RPi register (RD/RC)
req_cd  input  1  1 = data register, 0 = control register
wr_data  input  8  byte for write transactions; captured at accept
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
rd_data  output  8  byte from last completed read; held until next read completes
r_clk  output  1  link shift clock
r_le  output  1  link load/latch enable
r_rt  output  1  link register group select
r_cd  output  1  link data/control select
r_dout  output  1  serial data to RPi-side shift register
r_din  input  1  serial data from TI-side shift register

Behaviour:
- Reset (async, reset_n=0) forces:
  - state IDLE;
  - busy, done, r_clk, r_le, r_dout = 0;
  - r_rt = 0, r_cd = 0;
  - rd_data = 8'h00;
  - divider and bit counter = 0.
- Reset mid-transaction aborts immediately:
  - no done pulse;
  - rd_data unchanged from its reset value;
  - a partial shift is abandoned.
- States: IDLE, SETUP, LOAD_LO, LOAD_HI, BIT_LO, BIT_HI, LATCH, DONE.
- Each non-IDLE/non-DONE state lasts exactly HALF cycles, timed by the divider.
- Accept: in IDLE with req=1:
  - capture req_rt, req_cd and wr_data;
  - next cycle: busy=1, state SETUP, r_rt/r_cd driven with the captured values.
- r_rt/r_cd stay stable from SETUP through the last phase, and hold their value in DONE/IDLE until the next accept.
- Read (r_rt=1): SETUP -> LOAD_LO -> LOAD_HI -> BIT_LO/BIT_HI x8 -> DONE.
  - LOAD_LO/LOAD_HI: r_le=1; r_clk=0 then 1 (parallel-load pulse).
  - r_le returns to 0 on entering the first BIT_LO.
  - BIT_LO: r_clk=0. In the last cycle of BIT_LO, sample r_din into shift bit 7-i (MSB first).
  - BIT_HI: r_clk=1.
  - busy duration: 19*HALF cycles.
- Write (r_rt=0): SETUP -> BIT_LO/BIT_HI x8 -> LATCH -> DONE.
  - r_dout is driven with wr_data[7-i] from the start of BIT_LO of bit i, held through its BIT_HI.
  - LATCH: r_le=1, r_clk=0, r_dout=0.
  - busy duration: 18*HALF cycles.
- Bit counter is 4-bit, counts 0..7; exit to the next phase when bit 7's BIT_HI expires. No wrap.
- DONE lasts 1 cycle:
  - done=1, busy=0, r_clk=0, r_le=0;
  - for reads, rd_data updates in this same cycle (visible with done);
  - req is ignored in DONE.
  - Next cycle: IDLE. Minimum gap between done and the next busy is therefore 2 cycles.
- req while busy or in DONE is ignored; there is no queueing, and the requester must re-assert.
- wr_data/req_rt/req_cd changes after accept have no effect.
- r_clk never glitches; every r_clk and r_le transition is registered.

Test Plan:
- Reset with HALF=2: r_clk/r_le/r_dout/busy/done/rd_data all 0. Assert reset_n=0 mid-write at bit 3 -> all outputs return to reset values immediately, and no done pulse occurs.
- Write, req_rt=0, req_cd=1, wr_data=8'hA5, HALF=2:
  - r_rt=0, r_cd=1;
  - 8 r_clk pulses, each 2 low + 2 high;
  - r_dout sequence 1,0,1,0,0,1,0,1;
  - one r_le pulse of 2 cycles;
  - busy high 36 cycles, then done for 1 cycle.
- Read, req_rt=1, req_cd=0, with the r_din model shifting out 8'h3C on r_clk rising edges after the load pulse:
  - r_le high during the first r_clk pulse only;
  - rd_data=8'h3C, visible coincident with done;
  - busy high 38 cycles.
- req held high continuously:
  - back-to-back transactions occur with exactly 2 non-busy cycles between them;
  - a req pulse during busy is ignored, and exactly one done is produced per accepted req.
- HALF=1, write 8'hFF then read 8'h00: busy 18 and 19 cycles respectively. rd_data holds its previous value (8'h3C, or 0 after reset) until the read's done.
- Change wr_data and req_cd on the cycle after accept: the shifted bits and r_cd still reflect the accepted values.

Source files
------------

// File: rtl/tipi_link_seq.sv
// tipi_link_seq: sequencer for the TIPI serial register link (TD/TC reads, RD/RC writes, 8 bits MSB first)
//   req/req_rt/req_cd/wr_data : transaction request, sampled in IDLE only
//   busy/done/rd_data         : status, one-cycle done pulse, last read byte
//   r_clk/r_le/r_rt/r_cd      : registered link control pins
//   r_dout/r_din              : serial data to / from the CPLD shift registers
module tipi_link_seq #(
  parameter int HALF = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_rt,
  input  logic       req_cd,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
);
  typedef enum logic [2:0] {IDLE, SETUP, LOAD_LO, LOAD_HI, BIT_LO, BIT_HI, LATCH, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] div_q, div_d, wd_q, wd_d, sh_q, sh_d, rd_q, rd_d;
  logic [3:0] bit_q, bit_d;
  logic       rt_q, rt_d, cd_q, cd_d;
  logic       busy_q, busy_d, done_q, done_d, clk_q, clk_d, le_q, le_d, dout_q, dout_d;
  logic       fin;
  assign fin = div_q == 8'(HALF - 1);
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rt_d    = rt_q;
    cd_d    = cd_q;
    wd_d    = wd_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE:    if (req) begin
                 state_d = SETUP;
                 rt_d    = req_rt;
                 cd_d    = req_cd;
                 wd_d    = wr_data;
                 bit_d   = '0;
               end
      SETUP:   if (fin) state_d = rt_q ? LOAD_LO : BIT_LO;
      LOAD_LO: if (fin) state_d = LOAD_HI;
      LOAD_HI: if (fin) state_d = BIT_LO;
      // TI-side data is stable while r_clk is low; take it just before the rising edge
      BIT_LO:  if (fin) begin
                 state_d = BIT_HI;
                 if (rt_q) sh_d[~bit_q[2:0]] = r_din;
               end
      BIT_HI:  if (fin) begin
                 if (bit_q == 4'd7) begin
                   state_d = rt_q ? DONE : LATCH;
                   if (rt_q) rd_d = sh_q;
                 end else begin
                   state_d = BIT_LO;
                   bit_d   = bit_q + 4'd1;
                 end
               end
      LATCH:   if (fin) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    div_d  = (fin || state_q == IDLE || state_q == DONE) ? '0 : div_q + 8'd1;
    // pin levels are decoded from the next state so every pin comes straight off a flop
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
    clk_d  = state_d == LOAD_HI || state_d == BIT_HI;
    le_d   = state_d == LOAD_LO || state_d == LOAD_HI || state_d == LATCH;
    dout_d = !rt_d && (state_d == BIT_LO || state_d == BIT_HI) && wd_d[~bit_d[2:0]];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      wd_q    <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      rt_q    <= 1'b0;
      cd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clk_q   <= 1'b0;
      le_q    <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      wd_q    <= wd_d;
      sh_q    <= sh_d;
      rd_q    <= rd_d;
      rt_q    <= rt_d;
      cd_q    <= cd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clk_q   <= clk_d;
      le_q    <= le_d;
      dout_q  <= dout_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_q;
  assign r_clk   = clk_q;
  assign r_le    = le_q;
  assign r_rt    = rt_q;
  assign r_cd    = cd_q;
  assign r_dout  = dout_q;
endmodule

// File: tb/tb_tipi_link_seq.sv
// tb_tipi_link_seq: randomized self-checking bench for tipi_link_seq at HALF=2 and HALF=1
module tb_tipi_link_seq;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic       req1 = 1'b0, req2 = 1'b0, req_rt = 1'b0, req_cd = 1'b0;
  logic [7:0] wr_data = '0;
  logic       busy1, done1, r_clk1, r_le1, r_rt1, r_cd1, r_dout1, r_din1;
  logic       busy2, done2, r_clk2, r_le2, r_rt2, r_cd2, r_dout2, r_din2;
  logic [7:0] rd1, rd2;
  logic [7:0] dv1 = '0, dv2 = '0, sr1 = '0, sr2 = '0;
  logic [7:0] prev1 = '0, prev2 = '0;
  logic [6:0] o1, o2;
  int tests = 0, fails = 0;
  tipi_link_seq #(.HALF(2)) u2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .req_rt(req_rt), .req_cd(req_cd), .wr_data(wr_data),
    .busy(busy2), .done(done2), .rd_data(rd2), .r_clk(r_clk2), .r_le(r_le2), .r_rt(r_rt2),
    .r_cd(r_cd2), .r_dout(r_dout2), .r_din(r_din2));
  tipi_link_seq #(.HALF(1)) u1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .req_rt(req_rt), .req_cd(req_cd), .wr_data(wr_data),
    .busy(busy1), .done(done1), .rd_data(rd1), .r_clk(r_clk1), .r_le(r_le1), .r_rt(r_rt1),
    .r_cd(r_cd1), .r_dout(r_dout1), .r_din(r_din1));
  // TI-side shift register: parallel load on an r_clk rise with r_le high, else shift left
  always @(posedge r_clk2) sr2 <= r_le2 ? dv2 : {sr2[6:0], 1'b0};
  always @(posedge r_clk1) sr1 <= r_le1 ? dv1 : {sr1[6:0], 1'b0};
  assign r_din2 = sr2[7];
  assign r_din1 = sr1[7];
  assign o2 = {busy2, done2, r_clk2, r_le2, r_dout2, r_rt2, r_cd2};
  assign o1 = {busy1, done1, r_clk1, r_le1, r_dout1, r_rt1, r_cd1};
  task automatic run_txn(input bit s, input bit rt, input bit cd, input logic [7:0] d,
                         input logic [7:0] din, input string nm);
    int h, bad;
    logic [2:0] ph[$];
    logic [6:0] ex[$];
    logic [6:0] ob, bo, be;
    logic [7:0] rd, pv, b;
    h = s ? 1 : 2;
    b = rt ? 8'h00 : d;
    ph.push_back(3'b000);
    if (rt) begin
      ph.push_back(3'b010);
      ph.push_back(3'b110);
    end
    for (int i = 0; i < 8; i++) begin
      ph.push_back({2'b00, b[7-i]});
      ph.push_back({2'b10, b[7-i]});
    end
    if (!rt) ph.push_back(3'b010);
    foreach (ph[p]) for (int j = 0; j < h; j++) ex.push_back({2'b10, ph[p], rt, cd});
    ex.push_back({2'b01, 3'b000, rt, cd});
    ex.push_back({2'b00, 3'b000, rt, cd});
    ex.push_back({2'b00, 3'b000, rt, cd});
    pv = s ? prev1 : prev2;
    @(negedge clk);
    if (s) dv1 = din; else dv2 = din;
    req_rt = rt; req_cd = cd; wr_data = d;
    if (s) req1 = 1'b1; else req2 = 1'b1;
    @(negedge clk);
    if (s) req1 = 1'b0; else req2 = 1'b0;
    req_rt = ~rt; req_cd = ~cd; wr_data = ~d;
    bad = -1; bo = '0; be = '0;
    for (int k = 0; k < ex.size(); k++) begin
      ob = s ? o1 : o2;
      rd = s ? rd1 : rd2;
      if (ob !== ex[k] && bad < 0) begin bad = k; bo = ob; be = ex[k]; end
      if (k == ex.size() - 4) begin
        tests++;
        if (rd !== pv) begin fails++; $display("FAIL %s rd_hold: rd_data=%h expected %h", nm, rd, pv); end
      end
      if (k == ex.size() - 3) begin
        tests++;
        if (rd !== (rt ? din : pv)) begin fails++; $display("FAIL %s rd_at_done: rd_data=%h expected %h", nm, rd, rt ? din : pv); end
      end
      if (k == 10) begin if (s) req1 = 1'b1; else req2 = 1'b1; end
      if (k == 11) begin if (s) req1 = 1'b0; else req2 = 1'b0; end
      @(negedge clk);
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s waveform cycle %0d: {busy,done,clk,le,dout,rt,cd}=%b expected %b", nm, bad, bo, be);
    end
    if (rt) begin if (s) prev1 = din; else prev2 = din; end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({o2, rd2} !== 15'h0) begin fails++; $display("FAIL reset_h2: outputs=%b rd=%h expected all 0", o2, rd2); end
    tests++;
    if ({o1, rd1} !== 15'h0) begin fails++; $display("FAIL reset_h1: outputs=%b rd=%h expected all 0", o1, rd1); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({o2, o1} !== 14'h0) begin fails++; $display("FAIL idle_after_reset: outputs=%b/%b expected 0", o2, o1); end
  endtask
  task automatic test_write();
    run_txn(0, 0, 1, 8'hA5, 8'h00, "write_a5");
  endtask
  task automatic test_read();
    run_txn(0, 1, 0, 8'h77, 8'h3C, "read_3c");
  endtask
  task automatic test_half1();
    run_txn(1, 1, 0, 8'h12, 8'h3C, "h1_read_3c");
    run_txn(1, 0, 1, 8'hFF, 8'h00, "h1_write_ff");
    run_txn(1, 1, 1, 8'hC3, 8'h00, "h1_read_00");
  endtask
  task automatic test_back_to_back();
    int rises = 0, dones = 0, nb = 0, gaps_bad = 0;
    logic pb = 1'b0;
    @(negedge clk);
    req_rt = 1'b0; req_cd = 1'b1; wr_data = 8'($urandom); req2 = 1'b1;
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      if (k == 100) req2 = 1'b0;
      if (busy2) begin
        if (!pb && rises > 0 && nb != 2) gaps_bad++;
        if (!pb) rises++;
        nb = 0;
      end else nb++;
      if (done2) dones++;
      pb = busy2;
    end
    tests++;
    if (rises !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", rises); end
    tests++;
    if (dones !== rises) begin fails++; $display("FAIL b2b_dones: got %0d expected %0d", dones, rises); end
    tests++;
    if (gaps_bad !== 0) begin fails++; $display("FAIL b2b_gap: %0d gaps differ from 2 idle cycles", gaps_bad); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), $sformatf("rand%0d", n));
  endtask
  task automatic test_reset_abort();
    int dn = 0, bz = 0;
    @(negedge clk);
    req_rt = 1'b0; req_cd = 1'b1; wr_data = 8'hA5; req2 = 1'b1;
    @(negedge clk);
    req2 = 1'b0;
    repeat (14) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({o2, rd2} !== 15'h0) begin fails++; $display("FAIL abort_async: outputs=%b rd=%h expected all 0", o2, rd2); end
    repeat (3) begin @(negedge clk); if (done2) dn++; end
    reset_n = 1'b1;
    prev1 = '0; prev2 = '0;
    repeat (40) begin @(negedge clk); if (done2) dn++; if (busy2) bz++; end
    tests++;
    if (dn !== 0) begin fails++; $display("FAIL abort_no_done: %0d done pulses expected 0", dn); end
    tests++;
    if (bz !== 0 || rd2 !== 8'h00) begin fails++; $display("FAIL abort_idle: busy cycles %0d rd=%h expected 0/00", bz, rd2); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_half1();
    test_back_to_back();
    test_random();
    test_read();
    test_reset_abort();
    test_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
